// File: rtl/ogpu_quad_store_arbiter.sv
// Round-robin arbiter that merges NUM_CH raster quad streams into a shared FIFO
// and drains it to software over a 4-phase req/ack PIO handshake.
module ogpu_quad_store_arbiter #(
   parameter int NUM_CH     = 4,
   parameter int PIO_W      = 32,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 32,
   localparam int ID_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
   localparam int LVL_W     = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                      clk_clk,
   input  logic                      reset_reset_n,
   input  logic [NUM_CH-1:0]         ch_valid,
   output logic [NUM_CH-1:0]         ch_ready,
   input  logic [NUM_CH*2*PIO_W-1:0] ch_data,
   input  logic                      flush,
   output logic                      store_req,
   input  logic                      store_ack,
   output logic [PIO_W-1:0]          store_data_high,
   output logic [PIO_W-1:0]          store_data_low,
   output logic [ID_W-1:0]           store_ch_id,
   output logic [LVL_W-1:0]          fifo_level,
   output logic [CNT_W-1:0]          quad_count
);

   localparam int QW = 2 * PIO_W;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int EW = ID_W + QW;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_REQ      = 2'd1,
      ST_WAIT_LOW = 2'd2
   } state_t;

   state_t            state_r, state_next_s;
   logic [EW-1:0]     mem_r [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr_r, rd_ptr_r;
   logic [LVL_W-1:0]  count_r;
   logic [ID_W-1:0]   rr_ptr_r, grant_id_s, idx_s;
   logic [NUM_CH-1:0] grant_s;
   logic              grant_vld_s, full_s, push_s, pop_s, ack_done_s;
   logic [QW-1:0]     push_data_s;
   logic [QW-1:0]     ch_quad_s [NUM_CH];
   logic [EW-1:0]     head_s;
   logic              store_req_r;
   logic [PIO_W-1:0]  data_high_r, data_low_r;
   logic [ID_W-1:0]   ch_id_r;
   logic [CNT_W-1:0]  quad_count_r;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_split
      assign ch_quad_s[g] = ch_data[g*QW +: QW];
   end

   // First valid channel at or above the RR pointer, wrapping.
   always_comb begin
      grant_s     = '0;
      grant_id_s  = '0;
      grant_vld_s = 1'b0;
      push_data_s = '0;
      idx_s       = '0;
      for (int k = 0; k < NUM_CH; k++) begin
         idx_s = ID_W'((int'(rr_ptr_r) + k) % NUM_CH);
         if (!grant_vld_s && ch_valid[idx_s]) begin
            grant_s[idx_s] = 1'b1;
            grant_id_s     = idx_s;
            push_data_s    = ch_quad_s[idx_s];
            grant_vld_s    = 1'b1;
         end else begin
            grant_vld_s = grant_vld_s;
         end
      end
   end

   // Fullness uses the registered count only, so a same-cycle pop never frees a slot early.
   assign full_s   = (count_r == LVL_W'(FIFO_DEPTH));
   assign push_s   = grant_vld_s & ~full_s & ~flush;
   assign pop_s    = (state_r == ST_IDLE) & (count_r != '0) & ~flush;
   assign ch_ready = grant_s & {NUM_CH{~full_s & ~flush}};
   assign head_s   = mem_r[rd_ptr_r];

   // Egress handshake next-state.
   always_comb begin
      state_next_s = state_r;
      ack_done_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (pop_s) state_next_s = ST_REQ;
            else       state_next_s = ST_IDLE;
         end
         ST_REQ: begin
            if (store_ack) begin
               state_next_s = ST_WAIT_LOW;
               ack_done_s   = 1'b1;
            end else begin
               state_next_s = ST_REQ;
            end
         end
         ST_WAIT_LOW: begin
            if (!store_ack) state_next_s = ST_IDLE;
            else            state_next_s = ST_WAIT_LOW;
         end
         default: state_next_s = ST_IDLE;
      endcase
   end

   // FIFO storage.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem_r[i] <= '0;
      end else if (push_s) begin
         mem_r[wr_ptr_r] <= {grant_id_s, push_data_s};
      end
   end

   // FIFO pointers and occupancy; flush empties the queue without touching egress.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else if (flush) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         count_r  <= '0;
      end else begin
         if (push_s) wr_ptr_r <= wr_ptr_r + AW'(1);
         if (pop_s)  rd_ptr_r <= rd_ptr_r + AW'(1);
         case ({push_s, pop_s})
            2'b10:   count_r <= count_r + LVL_W'(1);
            2'b01:   count_r <= count_r - LVL_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Round-robin pointer moves past the channel just served.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         rr_ptr_r <= '0;
      end else if (push_s) begin
         rr_ptr_r <= (grant_id_s == ID_W'(NUM_CH - 1)) ? '0 : grant_id_s + ID_W'(1);
      end
   end

   // Handshake state and registered software-facing outputs.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state_r      <= ST_IDLE;
         store_req_r  <= 1'b0;
         data_high_r  <= '0;
         data_low_r   <= '0;
         ch_id_r      <= '0;
         quad_count_r <= '0;
      end else begin
         state_r     <= state_next_s;
         store_req_r <= (state_next_s == ST_REQ);
         if (pop_s) begin
            data_high_r <= head_s[QW-1:PIO_W];
            data_low_r  <= head_s[PIO_W-1:0];
            ch_id_r     <= head_s[EW-1:QW];
         end
         if (ack_done_s) quad_count_r <= quad_count_r + CNT_W'(1);
      end
   end

   assign store_req       = store_req_r;
   assign store_data_high = data_high_r;
   assign store_data_low  = data_low_r;
   assign store_ch_id     = ch_id_r;
   assign fifo_level      = count_r;
   assign quad_count      = quad_count_r;

endmodule

// File: tb/tb_ogpu_quad_store_arbiter.sv
// Bench for ogpu_quad_store_arbiter: directed scenarios plus random traffic,
// all outputs compared every cycle against a queue-based reference model.
module tb_ogpu_quad_store_arbiter;

   localparam int NUM_CH     = 4;
   localparam int PIO_W      = 32;
   localparam int FIFO_DEPTH = 16;
   localparam int CNT_W      = 4;
   localparam int ID_W       = 2;
   localparam int LVL_W      = 5;

   logic                      clk_clk = 1'b0;
   logic                      reset_reset_n = 1'b0;
   logic [NUM_CH-1:0]         ch_valid = '0;
   logic [NUM_CH-1:0]         ch_ready;
   logic [NUM_CH*2*PIO_W-1:0] ch_data = '0;
   logic                      flush = 1'b0;
   logic                      store_req;
   logic                      store_ack = 1'b0;
   logic [PIO_W-1:0]          store_data_high, store_data_low;
   logic [ID_W-1:0]           store_ch_id;
   logic [LVL_W-1:0]          fifo_level;
   logic [CNT_W-1:0]          quad_count;

   always #5 clk_clk = ~clk_clk;

   ogpu_quad_store_arbiter #(
      .NUM_CH(NUM_CH), .PIO_W(PIO_W), .FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)
   ) dut (
      .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
      .ch_valid(ch_valid), .ch_ready(ch_ready), .ch_data(ch_data),
      .flush(flush), .store_req(store_req), .store_ack(store_ack),
      .store_data_high(store_data_high), .store_data_low(store_data_low),
      .store_ch_id(store_ch_id), .fifo_level(fifo_level), .quad_count(quad_count)
   );

   // Reference model: a queue of pending quads plus the software-visible handshake view.
   int          m_q_ch[$];
   logic [63:0] m_q_data[$];
   int          m_rr, m_out_ch, m_hs;
   bit          m_req, m_wait_low;
   logic [63:0] m_out;

   bit          pend[NUM_CH];
   logic [63:0] pdata[NUM_CH];
   int          vmode, amode;
   bit          flush_next;
   int          push_log[$];
   int          n_checks, n_pass, n_fail;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_q_ch.delete();
      m_q_data.delete();
      m_rr = 0; m_out_ch = 0; m_hs = 0;
      m_req = 1'b0; m_wait_low = 1'b0; m_out = '0;
      for (int i = 0; i < NUM_CH; i++) pend[i] = 1'b0;
   endtask

   function automatic bit all_idle();
      bit any;
      any = 1'b0;
      for (int i = 0; i < NUM_CH; i++) any |= pend[i];
      return !any && m_q_ch.size() == 0 && !m_req && !m_wait_low;
   endfunction

   // One clock cycle: drive at negedge, compare, advance model, cross the posedge.
   task automatic step();
      int g, c;
      bit accept, full, pop;
      logic [NUM_CH-1:0] exp_ready;
      for (int i = 0; i < NUM_CH; i++) begin
         if (!pend[i]) begin
            case (vmode)
               1: pend[i] = ($urandom_range(0, 2) == 0);
               2: pend[i] = 1'b1;
               3: pend[i] = (i == 2);
               default: pend[i] = 1'b0;
            endcase
            if (pend[i]) pdata[i] = {$urandom(), $urandom()};
         end
         ch_valid[i] = pend[i];
         ch_data[i*64 +: 64] = pdata[i];
      end
      case (amode)
         1: store_ack = m_req;
         2: store_ack = 1'($urandom_range(0, 1));
         3: store_ack = 1'b1;
         default: store_ack = 1'b0;
      endcase
      flush = flush_next;
      flush_next = 1'b0;
      #1;
      full = (m_q_ch.size() == FIFO_DEPTH);
      g = -1;
      for (int k = 0; k < NUM_CH; k++) begin
         c = (m_rr + k) % NUM_CH;
         if (g < 0 && pend[c]) g = c;
      end
      accept = (g >= 0) && !full && !flush;
      exp_ready = accept ? NUM_CH'(1 << g) : '0;
      check("ch_ready", ch_ready, exp_ready);
      check("store_req", store_req, m_req);
      check("data_high", store_data_high, m_out[63:32]);
      check("data_low", store_data_low, m_out[31:0]);
      check("ch_id", store_ch_id, m_out_ch);
      check("fifo_level", fifo_level, m_q_ch.size());
      check("quad_count", quad_count, m_hs % 16);
      for (int i = 0; i < NUM_CH; i++) if (ch_ready[i] === 1'b1) push_log.push_back(i);
      pop = !m_req && !m_wait_low && m_q_ch.size() > 0 && !flush;
      if (m_req && store_ack) begin
         m_req = 1'b0; m_wait_low = 1'b1; m_hs++;
      end else if (m_wait_low && !store_ack) begin
         m_wait_low = 1'b0;
      end
      if (pop) begin
         m_out = m_q_data.pop_front();
         m_out_ch = m_q_ch.pop_front();
         m_req = 1'b1;
      end
      if (flush) begin
         m_q_ch.delete();
         m_q_data.delete();
      end
      if (accept) begin
         m_q_ch.push_back(g);
         m_q_data.push_back(pdata[g]);
         pend[g] = 1'b0;
         m_rr = (g + 1) % NUM_CH;
      end
      @(posedge clk_clk);
      @(negedge clk_clk);
   endtask

   task automatic drain();
      vmode = 0; amode = 1;
      for (int t = 0; t < 400 && !all_idle(); t++) step();
      step();
      check("drain_level", fifo_level, 0);
      check("drain_req", store_req, 0);
   endtask

   initial begin
      int pushed;
      n_checks = 0; n_pass = 0; n_fail = 0;
      vmode = 0; amode = 0; flush_next = 1'b0;
      model_reset();
      repeat (3) @(negedge clk_clk);
      reset_reset_n = 1'b1;
      step();

      // Single quad from channel 0 and a full handshake.
      pend[0] = 1'b1; pdata[0] = 64'h1122334455667788;
      step();
      step();
      check("t1_req", store_req, 1);
      check("t1_high", store_data_high, 32'h11223344);
      check("t1_low", store_data_low, 32'h55667788);
      check("t1_id", store_ch_id, 0);
      amode = 3; step();
      check("t1_req_drop", store_req, 0);
      check("t1_count", quad_count, 1);
      amode = 0; step(); step();

      // All channels valid, instant ack: strict rotation.
      push_log.delete();
      vmode = 2; amode = 1;
      repeat (40) step();
      check("rr_pushes", push_log.size() >= 8, 1);
      for (int k = 1; k < push_log.size(); k++)
         check("rr_order", push_log[k], (push_log[k-1] + 1) % NUM_CH);
      drain();

      // No ack, channel 2 streams until the FIFO is full.
      vmode = 3; amode = 0;
      repeat (24) step();
      check("fill_level", fifo_level, 16);
      check("fill_ready2", ch_ready[2], 0);
      check("fill_req", store_req, 1);
      vmode = 0;
      amode = 3; step();
      amode = 0; step();
      step();
      check("pop_level", fifo_level, 15);
      check("pop_ready", ch_ready, 4'b0100);
      step();
      check("refill_level", fifo_level, 16);
      drain();

      // Flush with five queued quads while a quad is presented.
      vmode = 3; amode = 0;
      for (int t = 0; t < 50 && !(m_q_ch.size() == 5 && m_req); t++) step();
      vmode = 0;
      check("pre_flush_level", fifo_level, 5);
      flush_next = 1'b1;
      step();
      check("flush_level", fifo_level, 0);
      check("flush_req_kept", store_req, 1);
      drain();

      // Asynchronous reset in the middle of a request.
      vmode = 3; amode = 0;
      repeat (4) step();
      vmode = 0;
      #3 reset_reset_n = 1'b0;
      #1;
      check("rst_req", store_req, 0);
      check("rst_high", store_data_high, 0);
      check("rst_low", store_data_low, 0);
      check("rst_id", store_ch_id, 0);
      check("rst_level", fifo_level, 0);
      check("rst_count", quad_count, 0);
      model_reset();
      ch_valid = '0;
      @(negedge clk_clk);
      reset_reset_n = 1'b1;
      step();

      // Seventeen handshakes wrap the 4-bit counter.
      amode = 1; pushed = 0;
      for (int t = 0; t < 400 && m_hs < 17; t++) begin
         if (!pend[0] && pushed < 17) begin
            pend[0] = 1'b1; pdata[0] = {$urandom(), $urandom()}; pushed++;
         end
         step();
      end
      check("wrap_count", quad_count, 17 % 16);
      drain();

      // Random traffic, random ack timing, occasional flush.
      vmode = 1; amode = 2;
      repeat (1500) begin
         if ($urandom_range(0, 29) == 0) flush_next = 1'b1;
         step();
      end
      drain();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
